// File: rtl/vga_text_renderer.sv
// Text-mode VGA renderer: raster counters, 5-stage text/font pixel pipeline,
// and a frame-synchronous double-buffer swap handshake.
`timescale 1ns/1ps
module vga_text_renderer #(
    parameter int H_VIS = 640,
    parameter int V_VIS = 480
) (
    input  logic        clk,
    input  logic        rst,
    output logic [12:0] read_address,
    input  logic [31:0] read_data,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_data,
    input  logic        swap_req,
    output logic        switch_buffer,
    output logic        swap_done,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);
    // Blanking geometry: 16/96/48 horizontal porches, 10/2/33 vertical.
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  H_LAST   = 10'(H_VIS + 159);
    localparam logic [9:0]  HS_FIRST = 10'(H_VIS + 16);
    localparam logic [9:0]  HS_LAST  = 10'(H_VIS + 111);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + 44);
    localparam logic [9:0]  VS_FIRST = 10'(V_VIS + 10);
    localparam logic [9:0]  VS_LAST  = 10'(V_VIS + 11);
    localparam logic [12:0] COLS     = 13'(H_VIS / 8);

    // state  | meaning
    // ACTIVE | visible lines are being scanned; swaps wait for the boundary
    // VBLANK | vertical blanking; buffer already switched for this frame
    typedef enum logic {ACTIVE = 1'b0, VBLANK = 1'b1} state_t;

    logic [9:0]       h_cnt, v_cnt;
    logic             vis_raw, hs_raw, vs_raw;
    logic [3:0]       vis_p, hs_p, vs_p;
    logic [2:0][2:0]  vrow_p;
    logic [3:0][2:0]  hpix_p;
    logic             inv_q;
    logic [2:0]       fg_q, bg_q;
    logic             pix_on;
    logic [2:0]       colour;
    logic             unused_bits;
    state_t           state, state_next;
    logic             swap_pending, fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign vis_raw = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign hs_raw  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_raw  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    assign read_address = vis_raw ? (13'(v_cnt[8:3]) * COLS + 13'(h_cnt[9:3])) : '0;
    assign unused_bits  = ^read_data[31:14];

    // Sync/visible flags travel the same depth as pixel data so all outputs align.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vis_p     <= '0;
            hs_p      <= '0;
            vs_p      <= '0;
            vrow_p    <= '0;
            hpix_p    <= '0;
            font_addr <= '0;
            inv_q     <= 1'b0;
            fg_q      <= '0;
            bg_q      <= '0;
        end else begin
            vis_p     <= {vis_p[2:0], vis_raw};
            hs_p      <= {hs_p[2:0], hs_raw};
            vs_p      <= {vs_p[2:0], vs_raw};
            vrow_p    <= {vrow_p[1:0], v_cnt[2:0]};
            hpix_p    <= {hpix_p[2:0], h_cnt[2:0]};
            font_addr <= {read_data[6:0], vrow_p[2]};
            inv_q     <= read_data[7];
            fg_q      <= read_data[10:8];
            bg_q      <= read_data[13:11];
        end
    end

    assign pix_on = font_data[3'd7 - hpix_p[3]] ^ inv_q;
    assign colour = pix_on ? fg_q : bg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= (vis_p[3] && colour[2]) ? 8'hFF : 8'h00;
            vga_g       <= (vis_p[3] && colour[1]) ? 8'hFF : 8'h00;
            vga_b       <= (vis_p[3] && colour[0]) ? 8'hFF : 8'h00;
            vga_hs      <= ~hs_p[3];
            vga_vs      <= ~vs_p[3];
            vga_blank_n <= vis_p[3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ACTIVE;
            swap_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (fire)
                swap_pending <= 1'b0;
            else if (swap_req)
                swap_pending <= 1'b1;
        end
    end

    // A request landing on the boundary cycle itself is honoured immediately.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            ACTIVE: begin
                if (h_cnt == '0 && v_cnt == V_VIS_C) begin
                    state_next = VBLANK;
                    fire       = swap_pending | swap_req;
                end
            end
            VBLANK: begin
                if (h_cnt == '0 && v_cnt == '0)
                    state_next = ACTIVE;
            end
            default: state_next = ACTIVE;
        endcase
    end

    assign switch_buffer = fire;
    assign swap_done     = fire;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer on a reduced raster (64x16 visible, standard
// porches) so several frames fit; random text/font contents against a raster model.
`timescale 1ns/1ps
module tb_vga_text_renderer;
    localparam int H_VIS    = 64;
    localparam int V_VIS    = 16;
    localparam int HT       = H_VIS + 160;
    localparam int VT       = V_VIS + 45;
    localparam int FRAME    = HT * VT;
    localparam int HS_FIRST = H_VIS + 16;
    localparam int HS_LAST  = H_VIS + 111;
    localparam int VS_FIRST = V_VIS + 10;
    localparam int VS_LAST  = V_VIS + 11;
    localparam int COLS     = H_VIS / 8;
    localparam int BOUND    = V_VIS * HT;

    logic        clk, rst, swap_req;
    logic [12:0] read_address;
    logic [31:0] read_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic        switch_buffer, swap_done;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n;

    logic [31:0] text_mem [0:4799];
    logic [7:0]  font_mem [0:1023];
    logic [31:0] rd_q [3];

    int tests, fails, cyc, pulses;
    logic pend_model, prev_hs, prev_vs;
    int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];

    vga_text_renderer #(.H_VIS(H_VIS), .V_VIS(V_VIS)) dut (
        .clk(clk), .rst(rst), .read_address(read_address), .read_data(read_data),
        .font_addr(font_addr), .font_data(font_data), .swap_req(swap_req),
        .switch_buffer(switch_buffer), .swap_done(swap_done),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Text memory with three-cycle read latency; font ROM answers within the cycle.
    always @(posedge clk) begin
        rd_q[0] <= text_mem[read_address];
        rd_q[1] <= rd_q[0];
        rd_q[2] <= rd_q[1];
    end
    assign read_data = rd_q[2];
    assign font_data = font_mem[font_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic logic [23:0] model_rgb(input int h, input int v);
        logic [31:0] word;
        logic [7:0]  bits;
        logic [2:0]  col;
        logic        px;
        if (h >= H_VIS || v >= V_VIS) return 24'h0;
        word = text_mem[(v / 8) * COLS + h / 8];
        bits = font_mem[int'(word[6:0]) * 8 + v % 8];
        px   = bits[7 - h % 8] ^ word[7];
        col  = px ? word[10:8] : word[13:11];
        return {{8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
    endfunction

    task automatic check_now(input logic req);
        int h, v, m, hm, vm, exp_addr;
        logic bnd, exp_sw;
        logic [23:0] exp_rgb, obs_rgb;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        exp_addr = (h < H_VIS && v < V_VIS) ? (v / 8) * COLS + h / 8 : 0;
        chk("read_address", 32'(read_address), 32'(exp_addr));
        if (h == 8 && v == 8) chk("addr_cell_1_1", 32'(read_address), 32'(COLS + 1));
        if (h == H_VIS - 1 && v == V_VIS - 1)
            chk("addr_last_cell", 32'(read_address), 32'(COLS * (V_VIS / 8) - 1));
        if (h == H_VIS + 36 && v == 2) chk("addr_hblank", 32'(read_address), 32'd0);

        bnd    = (h == 0 && v == V_VIS);
        exp_sw = bnd && (pend_model || req);
        chk("switch_buffer", 32'(switch_buffer), 32'(exp_sw));
        chk("swap_done", 32'(swap_done), 32'(exp_sw));
        if (switch_buffer === 1'b1) pulses++;
        pend_model = bnd ? 1'b0 : (pend_model | req);

        obs_rgb = {vga_r, vga_g, vga_b};
        if (cyc < 5) begin
            chk("rgb_startup", 32'(obs_rgb), 32'd0);
            chk("hs_startup", 32'(vga_hs), 32'd1);
            chk("vs_startup", 32'(vga_vs), 32'd1);
            chk("blank_startup", 32'(vga_blank_n), 32'd0);
        end else begin
            m  = cyc - 5;
            hm = m % HT;
            vm = (m / HT) % VT;
            exp_rgb = model_rgb(hm, vm);
            chk("rgb", 32'(obs_rgb), 32'(exp_rgb));
            chk("hs", 32'(vga_hs), 32'(!(hm >= HS_FIRST && hm <= HS_LAST)));
            chk("vs", 32'(vga_vs), 32'(!(vm >= VS_FIRST && vm <= VS_LAST)));
            chk("blank_n", 32'(vga_blank_n), 32'(hm < H_VIS && vm < V_VIS));
            if (vm >= 8 && vm < 16 && hm >= 8 && hm < 16)
                chk("cell_0741", 32'(obs_rgb), (hm % 8 == 0 || hm % 8 == 7) ? 32'hFFFFFF : 32'h0);
            if (vm >= 8 && vm < 16 && hm >= 16 && hm < 24)
                chk("cell_07C1", 32'(obs_rgb), (hm % 8 == 0 || hm % 8 == 7) ? 32'h0 : 32'hFFFFFF);
        end

        if (prev_hs === 1'b1 && vga_hs === 1'b0) hs_fall.push_back(cyc);
        if (prev_hs === 1'b0 && vga_hs === 1'b1) hs_rise.push_back(cyc);
        if (prev_vs === 1'b1 && vga_vs === 1'b0) vs_fall.push_back(cyc);
        if (prev_vs === 1'b0 && vga_vs === 1'b1) vs_rise.push_back(cyc);
        prev_hs = vga_hs;
        prev_vs = vga_vs;
    endtask

    task automatic cycle(input logic req);
        swap_req = req;
        #1;
        check_now(req);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
        chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({tag, "_switch"}, 32'(switch_buffer), 32'd0);
        chk({tag, "_done"}, 32'(swap_done), 32'd0);
        chk({tag, "_addr"}, 32'(read_address), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; pulses = 0;
        pend_model = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        rst = 1'b0; swap_req = 1'b0;
        for (int i = 0; i < 4800; i++) text_mem[i] = $urandom();
        for (int i = 0; i < 1024; i++) font_mem[i] = 8'($urandom());
        text_mem[COLS + 1] = 32'h0000_0741;
        text_mem[COLS + 2] = 32'h0000_07C1;
        for (int r = 0; r < 8; r++) font_mem[8'h41 * 8 + r] = 8'h81;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        run_to(2 * HT + 10);
        chk("hs_first_fall", 32'(qget(hs_fall, 0)), 32'(HS_FIRST + 5));
        chk("hs_low_len", 32'(qget(hs_rise, 0) - qget(hs_fall, 0)), 32'd96);
        chk("line_period", 32'(qget(hs_fall, 1) - qget(hs_fall, 0)), 32'(HT));

        run_to(4 * HT + 10);
        cycle(1'b1);
        run_to(4 * HT + 50);
        cycle(1'b1);
        run_to(BOUND + 1);
        chk("two_req_one_swap", 32'(pulses), 32'd1);

        run_to(FRAME + BOUND);
        cycle(1'b1);
        chk("boundary_req_swap", 32'(pulses), 32'd2);

        run_to(FRAME + (VS_FIRST + 3) * HT);
        chk("vs_first_fall", 32'(qget(vs_fall, 0)), 32'(VS_FIRST * HT + 5));
        chk("vs_low_len", 32'(qget(vs_rise, 0) - qget(vs_fall, 0)), 32'(2 * HT));
        chk("frame_period", 32'(qget(vs_fall, 1) - qget(vs_fall, 0)), 32'(FRAME));

        run_to(2 * FRAME + BOUND + 1);
        chk("no_leftover_swap", 32'(pulses), 32'd2);

        run_to(3 * FRAME + 4 * HT);
        cycle(1'b1);
        run_to(3 * FRAME + 8 * HT);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        @(negedge clk);
        rst = 1'b1;
        cyc = 0; pulses = 0; pend_model = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1;

        run_to(BOUND + HT);
        chk("post_reset_no_swap", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_text_renderer.md
VGA_TEXT_RENDERER -- requirements
Module: vga_text_renderer

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-003 SHALL have port clk, input, 1, pixel clock (25 MHz); all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port read_address, output, 13, text-buffer word address to the double buffer.
REQ-006 SHALL have port read_data, input, 32, text word, valid exactly 3 cycles after read_address is driven.
REQ-007 SHALL have port font_addr, output, 10, font ROM address {glyph[6:0], row[2:0]}.
REQ-008 SHALL have port font_data, input, 8, glyph row, valid 1 cycle after font_addr; bit 7 is the leftmost pixel.
REQ-009 SHALL have port swap_req, input, 1, one-cycle pulse from the writer requesting a buffer swap.
REQ-010 SHALL have port switch_buffer, output, 1, one-cycle swap pulse to the double buffer.
REQ-011 SHALL have port swap_done, output, 1, one-cycle pulse coincident with switch_buffer.
REQ-012 SHALL have ports vga_r, vga_g and vga_b, outputs, 8 each, pixel colour.
REQ-013 SHALL have ports vga_hs, vga_vs and vga_blank_n, outputs, 1 each; syncs active-low, blank_n low outside the visible area.

Function
REQ-014 SHALL keep h_cnt at 0..799, wrapping to 0; v_cnt SHALL increment on the h_cnt wrap at 0..524, wrapping to 0.
REQ-015 SHALL assert raw hsync for h_cnt 656..751 and raw vsync for v_cnt 490..491; raw visible SHALL be h_cnt<640 and v_cnt<480.
REQ-016 SHALL drive read_address = v_cnt[8:3]*80 + h_cnt[9:3] (range 0..4799) when raw visible, and 0 otherwise; it SHALL be combinational from the counters (stage 0).
REQ-017 SHALL decode the text word as: [6:0] glyph, [7] inverse, [10:8] fg RGB, [13:11] bg RGB; bits [31:14] SHALL be ignored.
REQ-018 SHALL register font_addr = {read_data[6:0], v_cnt[2:0] delayed 3 cycles} at stage 3, so font_data is valid at stage 4.
REQ-019 SHALL select pixel bit = font_data[7 - hpix], where hpix is h_cnt[2:0] delayed 4 cycles; the result SHALL be XOR'd with the delayed inverse bit.
REQ-020 SHALL output the fg colour when the bit is 1 and the bg colour otherwise; each colour bit SHALL map to 8'hFF or 8'h00.
REQ-021 SHALL register RGB, hs, vs and blank_n at stage 5; total latency from counter value to output SHALL be 5 cycles for every signal, with sync/blank delayed through a matching pipeline.
REQ-022 SHALL force RGB to 0 whenever the delayed visible flag is 0.
REQ-023 SHALL set swap_pending on a swap_req pulse.
REQ-024 SHALL evaluate the swap boundary at counter values h_cnt=0, v_cnt=480.
REQ-025 SHALL, at the swap boundary, assert switch_buffer and swap_done for exactly 1 cycle and clear swap_pending if (swap_pending | swap_req) is true.
REQ-026 SHALL service a swap_req arriving on the boundary cycle immediately and SHALL NOT leave it pending.
REQ-027 SHALL collapse multiple swap_req pulses within one frame into a single swap.
REQ-028 SHALL have an FSM with states ACTIVE and VBLANK: ACTIVE to VBLANK at v_cnt=480,h_cnt=0; VBLANK to ACTIVE at v_cnt=0,h_cnt=0.
REQ-029 SHALL issue swaps only on the ACTIVE to VBLANK transition.

Reset
REQ-030 SHALL, on rst low, clear h_cnt, v_cnt, all pipeline stages, swap_pending and font_addr, and set FSM=ACTIVE.
REQ-031 SHALL hold switch_buffer=0, swap_done=0, RGB=0, vga_hs=1, vga_vs=1 and vga_blank_n=0 during reset.
REQ-032 SHALL, on reset release, start counting from h_cnt=0,v_cnt=0 on the first clock edge.
REQ-033 SHALL, when reset occurs mid-frame, discard pending swaps and in-flight pipeline data.

Verification
REQ-034 SHALL cover timing: after reset, vga_hs low for 96 cycles starting 661 cycles after release; line period 800; vga_vs low on lines 490-491; frame period 420000 cycles.
REQ-035 SHALL cover addressing: h=8,v=8 gives read_address=81; h=639,v=479 gives 4799; h=700 gives 0.
REQ-036 SHALL cover pixel output: memory model (latency 3) returns 32'h0000_0741 and font model returns 8'h81; then 5 cycles after address, pixels 0 and 7 of the cell are FFFFFF and pixels 1-6 are 000000.
REQ-037 SHALL cover inverse video: word 32'h0000_07C1 with the same font gives pixels 0 and 7 black and pixels 1-6 white.
REQ-038 SHALL cover swap handshake: two swap_req pulses at v=100 give exactly one switch_buffer/swap_done pulse at h=0,v=480; swap_req on the boundary cycle swaps that cycle and none occurs next frame.
REQ-039 SHALL cover mid-operation reset: pulse rst low at v=200 with a swap pending; outputs take reset values, counters restart at 0, and no switch_buffer occurs in the following frame.
